// File: rtl/reg_mux_arb_pkg.sv
// rtl/reg_mux_arb_pkg.sv - mode constants and one-hot grant encoder shared by the mux slice
package mux_pkg;

  localparam int MODE_IDX  = 0;
  localparam int MODE_PRIO = 1;
  localparam int MODE_RR   = 2;

  localparam int MAX_CH = 64;

  // Callers zero-extend their grant vector to MAX_CH and truncate the result to their index width.
  function automatic int unsigned grant_to_idx(input logic [MAX_CH-1:0] grant);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (grant[i]) idx = int'(unsigned'(i));
    end
    return idx;
  endfunction

endpackage

// File: rtl/reg_mux_arb_if.sv
// rtl/reg_mux_arb_if.sv - producer lanes plus shared consumer port of the registered mux
interface reg_mux_arb_if #(
  parameter int WIDTH = 31,
  parameter int N_CH  = 4
);
  localparam int IDX_W = $clog2(N_CH);

  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic [IDX_W-1:0]      sel;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [IDX_W-1:0]      out_idx;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/reg_mux_arb_rr_arbiter.sv
// rtl/reg_mux_arb_rr_arbiter.sv - round-robin one-hot arbiter owning the rotation pointer
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_valid,
  input  logic            i_advance,
  output logic [N_CH-1:0] o_grant
);
  localparam int IDX_W = $clog2(N_CH);
  localparam int CW    = IDX_W + 1;

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;

  // Scan from the pointer upwards; wrap explicitly so non-power-of-2 N_CH never indexes past the top.
  always_comb begin
    logic [CW-1:0] c;
    logic          found;
    o_grant = '0;
    found   = 1'b0;
    c       = '0;
    for (int off = 0; off < N_CH; off++) begin
      c = {1'b0, r_ptr} + CW'(off);
      if (c >= CW'(N_CH)) c = c - CW'(N_CH);
      if (!found && i_valid[c[IDX_W-1:0]]) begin
        o_grant[c[IDX_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

  assign w_idx = IDX_W'(grant_to_idx(MAX_CH'(o_grant)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && |o_grant) begin
      r_ptr <= (int'(w_idx) == N_CH - 1) ? '0 : w_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/reg_mux_arb.sv
// rtl/reg_mux_arb.sv - N-way registered valid/ready mux with index, priority or round-robin select
module reg_mux_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 31,
  parameter int N_CH  = 4,
  parameter int MODE  = 2
) (
  input logic          aclk,
  input logic          arst,
  reg_mux_arb_if.slave bus
);
  localparam int IDX_W = $clog2(N_CH);

  logic             w_load_en;
  logic [N_CH-1:0]  w_req;
  logic [N_CH-1:0]  w_grant;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_data;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [IDX_W-1:0] r_idx;

  // Gating requests with load_en (and reset) keeps every in_ready low during a stall or reset.
  assign w_load_en = (!r_valid || bus.out_ready) && !arst;
  assign w_req     = bus.in_valid & {N_CH{w_load_en}};

  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_arbiter #(.N_CH(N_CH)) u_rr (
        .clk       (aclk),
        .rst       (arst),
        .i_valid   (w_req),
        .i_advance (w_load_en),
        .o_grant   (w_grant)
      );
    end else if (MODE == MODE_PRIO) begin : g_prio
      always_comb begin
        logic found;
        w_grant = '0;
        found   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
          if (!found && w_req[i]) begin
            w_grant[i] = 1'b1;
            found      = 1'b1;
          end
        end
      end
    end else begin : g_idx
      always_comb begin
        w_grant = '0;
        for (int i = 0; i < N_CH; i++) begin
          if (bus.sel == IDX_W'(i) && w_req[i]) w_grant[i] = 1'b1;
        end
      end
    end
  endgenerate

  assign w_idx = IDX_W'(grant_to_idx(MAX_CH'(w_grant)));

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_data = w_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
    end else if (w_load_en) begin
      r_valid <= |w_grant;
      if (|w_grant) begin
        r_data <= w_data;
        r_idx  <= w_idx;
      end
    end
  end

  assign bus.in_ready  = w_grant;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_idx   = r_idx;

endmodule
